// File: rtl/fu_div_pkg.sv
// Shared definitions for the fu_div iterative divider: op codes, FSM states, default latency.
// Optional feature macro used by fu_div: FU_DIV_BUSY_ERR_EN (adds the err output).
package fu_div_pkg;

  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  localparam int LATENCY_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  // Two's-complement negate when n is set; used both for operand magnitudes and result signs.
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring step: two chained shift/compare/subtract stages producing 2 quotient bits.
module div_r4_step (
  input  logic [31:0] rem_i,
  input  logic [1:0]  dvd_bits_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [1:0]  q_o
);

  logic [32:0] t1, t2;
  logic [31:0] r1;
  logic        q1, q0;

  // The shifted remainder needs 33 bits; after a restoring step it is again below the divisor.
  always_comb begin
    t1    = {rem_i, dvd_bits_i[1]};
    q1    = (t1 >= {1'b0, dvs_i});
    r1    = q1 ? 32'(t1 - {1'b0, dvs_i}) : t1[31:0];
    t2    = {r1, dvd_bits_i[0]};
    q0    = (t2 >= {1'b0, dvs_i});
    rem_o = q0 ? 32'(t2 - {1'b0, dvs_i}) : t2[31:0];
    q_o   = {q1, q0};
  end

endmodule

// File: rtl/fu_div.sv
// Fixed-latency 32-bit DIV/DIVU/REM/REMU unit: 16 radix-4 iterations, sign fix-up, then padding.
// Define FU_DIV_BUSY_ERR_EN to add the err output flagging EN issued while busy.
module fu_div
  import fu_div_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] res,
  output logic        busy,
  output logic        done
`ifdef FU_DIV_BUSY_ERR_EN
  ,
  output logic        err
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] rslt_q, rslt_d;
  logic [31:0] res_q, res_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [31:0] step_rem;
  logic [1:0]  step_q;

  // funct3 0..3 decode as DIVU: neither signed nor remainder.
  assign sgn = funct3[2] & ~funct3[0];

  div_r4_step u_step (
    .rem_i      (rem_q),
    .dvd_bits_i (dvd_q[31:30]),
    .dvs_i      (dvs_q),
    .rem_o      (step_rem),
    .q_o        (step_q)
  );

  // The dividend register doubles as the quotient register: quotient bits shift in as dividend bits leave.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    rslt_d   = rslt_q;
    res_d    = res_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          state_d  = ST_ITER;
          busy_d   = 1'b1;
          cnt_d    = 5'd0;
          dvd_d    = neg_if(sgn & rs1_data[31], rs1_data);
          dvs_d    = neg_if(sgn & rs2_data[31], rs2_data);
          rem_d    = 32'd0;
          is_rem_d = funct3[2] & funct3[1];
          neg_q_d  = sgn & (rs1_data[31] ^ rs2_data[31]);
          neg_r_d  = sgn & rs1_data[31];
          dz_d     = (rs2_data == 32'd0);
        end
      end
      ST_ITER: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[29:0], step_q};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) state_d = ST_FIX;
      end
      ST_FIX: begin
        cnt_d   = cnt_q + 5'd1;
        state_d = ST_WAIT;
        if (is_rem_q)  rslt_d = neg_if(neg_r_q, rem_q);
        else if (dz_q) rslt_d = 32'hFFFF_FFFF;
        else           rslt_d = neg_if(neg_q_q, dvd_q);
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(LATENCY - 1)) begin
          res_d   = rslt_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      rslt_q   <= 32'd0;
      res_q    <= 32'd0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      rslt_q   <= rslt_d;
      res_q    <= res_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef FU_DIV_BUSY_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= EN & busy_q;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_fu_div.sv
// Self-checking bench for fu_div: vector table, directed corner sequences and randomized ops vs. a reference model.
module tb_fu_div;

  localparam int LAT = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [31:0] res;
  logic        busy;
  logic        done;
`ifdef FU_DIV_BUSY_ERR_EN
  logic        err;
`endif

  int nvec = 0;
  int nmis = 0;

  fu_div #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .res      (res),
    .busy     (busy),
    .done     (done)
`ifdef FU_DIV_BUSY_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit     is_s = (f3 == 3'd4) || (f3 == 3'd6);
    bit     is_r = (f3 == 3'd6) || (f3 == 3'd7);
    longint sa, sb;
    if (b == 32'd0) return is_r ? a : 32'hFFFF_FFFF;
    if (is_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return is_r ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_r ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op; inj>0 drives a second EN sampled at edge k+inj. Returns result and a protocol-ok flag.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int inj,
                       output logic [31:0] r, output logic ok);
    logic [31:0] res0;
    logic        e_err;
    ok = 1'b1;
    @(negedge clk);
    EN = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    EN = 1'b0;
    res0 = res;
    if (!busy || done) ok = 1'b0;
    for (int m = 1; m <= LAT; m++) begin
      if (m == inj) begin
        @(negedge clk);
        EN = 1'b1; funct3 = 3'($urandom_range(0, 7)); rs1_data = $urandom; rs2_data = $urandom;
      end
      @(posedge clk); #1;
      EN = 1'b0;
      if (m < LAT) begin
        if (!busy || done || res !== res0) ok = 1'b0;
      end else begin
        if (busy || !done) ok = 1'b0;
      end
`ifdef FU_DIV_BUSY_ERR_EN
      e_err = (inj != 0) && (m == inj);
      if (err !== e_err) ok = 1'b0;
`else
      e_err = 1'b0;
`endif
    end
    r = res;
  endtask

  vec_t        tbl[$];
  logic [31:0] r;
  logic        ok;
  logic [31:0] a, b;
  logic [2:0]  f3;
  bit          seen_done;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{3'd5, 32'd100,         32'd7,          32'd14});
    tbl.push_back('{3'd4, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD});
    tbl.push_back('{3'd6, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF});
    tbl.push_back('{3'd7, 32'hFFFF_FFF9,   32'd2,          32'd1});
    tbl.push_back('{3'd4, 32'd5,           32'd0,          32'hFFFF_FFFF});
    tbl.push_back('{3'd7, 32'd5,           32'd0,          32'd5});
    tbl.push_back('{3'd6, 32'hFFFF_FFFB,   32'd0,          32'hFFFF_FFFB});
    tbl.push_back('{3'd4, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000});
    tbl.push_back('{3'd6, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0});
    tbl.push_back('{3'd1, 32'hFFFF_FFF9,   32'd2,          32'h7FFF_FFFC});
    tbl.push_back('{3'd5, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF});
    tbl.push_back('{3'd6, 32'd7,           32'hFFFF_FFFE,  32'd1});

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", res, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, 0, r, ok);
      chk($sformatf("vec%0d_res", i), r, tbl[i].exp);
      chk($sformatf("vec%0d_timing", i), {31'd0, ok}, 32'd1);
    end

    // Abort mid-operation: reset at cycle 10 clears outputs and suppresses done.
    @(negedge clk);
    EN = 1'b1; funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3;
    @(posedge clk); #1;
    EN = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    do_op(3'd5, 32'd9, 32'd3, 0, r, ok);
    chk("after_abort_res", r, 32'd3);
    chk("after_abort_timing", {31'd0, ok}, 32'd1);

    // EN while busy at edge k+5 is ignored.
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5, r, ok);
    chk("busy_en_res", r, 32'hFFFF_FFFD);
    chk("busy_en_timing", {31'd0, ok}, 32'd1);

    // EN held at the done edge is ignored; unit stays idle afterwards.
    do_op(3'd5, 32'd50, 32'd5, LAT, r, ok);
    chk("done_en_res", r, 32'd10);
    chk("done_en_timing", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    chk("done_en_idle", {31'd0, busy}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (n == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f3 = 3'd4; end
      do_op(f3, a, b, 0, r, ok);
      chk($sformatf("rnd%0d_f%0d_%08h_%08h", n, f3, a, b), r, ref_div(f3, a, b));
      chk($sformatf("rnd%0d_timing", n), {31'd0, ok}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
